// File: rtl/poci_readout.sv
// Serial readout of auxiliary registers and snapshotted channel data.
// Bytes are addressed through an auto-incrementing pointer and shifted out one bit per sclk.
module poci_readout #(
  parameter int NUM_CH    = 8,
  parameter int CH_WIDTH  = 50,
  parameter int NUM_AUX   = 3,
  parameter int AUTO_INC  = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic                         sclk,
  input  logic                         rstn,
  input  logic [NUM_CH*CH_WIDTH-1:0]   ch_data,
  input  logic [NUM_AUX*8-1:0]         aux_data,
  input  logic                         capture,
  input  logic                         addr_load,
  input  logic [7:0]                   addr_in,
  input  logic                         read_en,
  output logic                         serial_out,
  output logic                         byte_done,
  output logic                         busy,
  output logic [7:0]                   addr_cur
);

  localparam int BPC        = (CH_WIDTH + 7) / 8;
  localparam int LAST_ADDR  = NUM_AUX + NUM_CH * BPC;
  localparam int SW         = NUM_CH * BPC * 8;
  localparam logic [7:0] LAST_ADDR8 = 8'(LAST_ADDR);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   shadow, shadow_cap;
  logic [7:0]      shreg, shreg_nxt;
  logic [2:0]      bit_cnt, cnt_nxt;
  logic            sout_nxt, done_nxt;
  logic [7:0]      addr_nxt, eff_addr, rd_byte, inc_addr;
  logic            load;
  logic            take_capture;

  function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] idx);
    logic r;
    if (MSB_FIRST != 0) begin
      r = b[3'd7 - idx];
    end else begin
      r = b[idx];
    end
    return r;
  endfunction

  // Zero-pad each channel up to whole bytes for the shadow image
  always_comb begin
    logic [BPC*8-1:0] padded;
    shadow_cap = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      padded = '0;
      padded[CH_WIDTH-1:0] = ch_data[c*CH_WIDTH +: CH_WIDTH];
      shadow_cap[c*BPC*8 +: BPC*8] = padded;
    end
  end

  // Effective address: a load in IDLE bypasses the pointer for this byte
  always_comb begin
    if (state == IDLE && addr_load) begin
      eff_addr = addr_in;
    end else begin
      eff_addr = addr_cur;
    end
    if (eff_addr >= LAST_ADDR8) begin
      inc_addr = 8'd1;
    end else begin
      inc_addr = eff_addr + 8'd1;
    end
  end

  // Address decode; constant-index matching keeps every unmapped address at zero
  always_comb begin
    rd_byte = 8'h00;
    for (int k = 0; k < NUM_AUX; k++) begin
      if (eff_addr == 8'(k + 1)) begin
        rd_byte = aux_data[k*8 +: 8];
      end else begin
        rd_byte = rd_byte;
      end
    end
    for (int k = 0; k < NUM_CH * BPC; k++) begin
      if (eff_addr == 8'(NUM_AUX + 1 + k)) begin
        rd_byte = shadow[k*8 +: 8];
      end else begin
        rd_byte = rd_byte;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    sout_nxt  = serial_out;
    done_nxt  = 1'b0;
    addr_nxt  = addr_cur;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (addr_load) begin
          addr_nxt = addr_in;
        end else begin
          addr_nxt = addr_cur;
        end
        if (read_en) begin
          load = 1'b1;
        end else begin
          sout_nxt = 1'b0;
        end
      end
      SHIFT: begin
        if (bit_cnt == 3'd7) begin
          if (read_en) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
            sout_nxt  = 1'b0;
          end
        end else begin
          cnt_nxt  = bit_cnt + 3'd1;
          sout_nxt = pick_bit(shreg, bit_cnt + 3'd1);
          done_nxt = (bit_cnt == 3'd6);
        end
      end
      default: begin
        state_nxt = IDLE;
        sout_nxt  = 1'b0;
      end
    endcase
    if (load) begin
      shreg_nxt = rd_byte;
      cnt_nxt   = 3'd0;
      sout_nxt  = pick_bit(rd_byte, 3'd0);
      state_nxt = SHIFT;
      if (AUTO_INC != 0) begin
        addr_nxt = inc_addr;
      end else begin
        addr_nxt = eff_addr;
      end
    end else begin
      shreg_nxt = shreg_nxt;
    end
  end

  assign take_capture = capture && (state == IDLE);

  // State, shifter, pointer and registered outputs
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      shreg      <= 8'h00;
      bit_cnt    <= 3'd0;
      serial_out <= 1'b0;
      byte_done  <= 1'b0;
      busy       <= 1'b0;
      addr_cur   <= 8'h00;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= cnt_nxt;
      serial_out <= sout_nxt;
      byte_done  <= done_nxt;
      busy       <= (state_nxt == SHIFT);
      addr_cur   <= addr_nxt;
    end
  end

  // Snapshot register; the decode above reads the pre-capture image on a shared edge
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      shadow <= '0;
    end else if (take_capture) begin
      shadow <= shadow_cap;
    end else begin
      shadow <= shadow;
    end
  end

endmodule

// File: doc/poci_readout.md
POCI_READOUT -- requirements
Module: poci_readout

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- NUM_CH, 8, number of data channels.
- CH_WIDTH, 50, bits per channel.
- NUM_AUX, 3, number of 8-bit auxiliary registers.
- AUTO_INC, 1, post-increment the read address after each byte.
- MSB_FIRST, 0, bit order (0 = bit 0 first).
REQ-002 The block SHALL define the derived values BPC = ceil(CH_WIDTH/8) and LAST_ADDR = NUM_AUX + NUM_CH*BPC; NUM_AUX+NUM_CH*BPC <= 255 is a legal-configuration requirement.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- sclk, in, 1, the single clock.
- rstn, in, 1, asynchronous active-low reset.
- ch_data, in, NUM_CH*CH_WIDTH, flat channel bus; channel c occupies [c*CH_WIDTH +: CH_WIDTH].
- aux_data, in, NUM_AUX*8, flat auxiliary bytes; aux k occupies [(k-1)*8 +: 8].
- capture, in, 1, snapshot request.
- addr_load, in, 1, load addr_in into the address pointer.
- addr_in, in, 8, byte address to load.
- read_en, in, 1, start/continue serial readout.
- serial_out, out, 1, serial data.
- byte_done, out, 1, high while the 8th bit of a byte is on serial_out.
- busy, out, 1, shifting in progress.
- addr_cur, out, 8, current address pointer.

Function
REQ-004 Address map: 0 = reserved, reads 0x00; 1..NUM_AUX = aux_data byte k, sampled live; NUM_AUX+1+c*BPC+b = byte b of channel c's shadow.
REQ-005 Shadow byte b SHALL be channel bits [8b+7:8b], with byte 0 as the LSB; the final partial byte SHALL be zero-padded in its upper bits.
REQ-006 Any address > LAST_ADDR SHALL read 0x00; no X is ever driven.
REQ-007 Shadow: on a sclk edge with capture=1 and busy=0, all NUM_CH channels SHALL be copied together; capture with busy=1 SHALL be ignored.
REQ-008 When capture and a byte load occur on the same edge, the loaded byte SHALL come from the pre-capture shadow.
REQ-009 The FSM SHALL have two states: IDLE (busy=0) and SHIFT (busy=1).
REQ-010 IDLE, addr_load=1: addr_cur <= addr_in.
REQ-011 IDLE, read_en=1: the byte at the effective address SHALL be loaded. The effective address is addr_in if addr_load=1, else addr_cur.
- On that edge serial_out <= first bit, bit counter = 0, next state SHIFT.
REQ-012 Address post-increment (AUTO_INC=1) SHALL occur on every byte-load edge: addr_cur <= effective address + 1.
- LAST_ADDR (or any address >= LAST_ADDR) wraps to 1; address 0 is never generated by increment.
- With AUTO_INC=0, addr_cur <= effective address.
REQ-013 SHIFT: each edge SHALL advance serial_out to the next bit; 8 bits occupy exactly 8 consecutive cycles.
- MSB_FIRST=0 order: bit0..bit7.
- MSB_FIRST=1 order: bit7..bit0.
REQ-014 byte_done SHALL be high for exactly the one cycle in which the 8th bit is on serial_out.
REQ-015 End of byte, read_en=1 at that edge: the next byte SHALL load at addr_cur and the FSM stays in SHIFT, with no idle gap between bytes.
REQ-016 End of byte, read_en=0: the FSM SHALL go to IDLE with serial_out <= 0.
REQ-017 read_en deasserted mid-byte SHALL NOT abort the byte; the current byte always completes.
REQ-018 addr_load in SHIFT SHALL be ignored.
REQ-019 Latency: the first bit SHALL appear on serial_out one sclk edge after read_en is sampled high.

Reset
REQ-020 rstn low SHALL asynchronously force: serial_out=0, byte_done=0, busy=0, addr_cur=0, bit counter=0, shift register=0, shadow=0, state=IDLE.
REQ-021 Reset mid-byte SHALL discard the byte; after rstn releases, the next read at address 0 yields 0x00.

Verification (NUM_CH=8, CH_WIDTH=50, NUM_AUX=3, LAST_ADDR=59, default parameters unless stated)
REQ-022 The bench SHALL cover these directed scenarios:
- Reset asserted -> serial_out=0, busy=0, byte_done=0, addr_cur=0.
- aux byte 1 = 0xA5, addr_load with addr_in=1 plus read_en for 1 cycle -> serial_out 1,0,1,0,0,1,0,1; byte_done in the 8th cycle; addr_cur=2; return to IDLE.
- ch0=50'h3_0000_0000_00FF, capture, read addr 4 -> 0xFF; read addr 10 -> 0x03 (zero padding); MSB_FIRST=1 on addr 10 -> 0,0,0,0,0,0,1,1.
- Load addr 58, hold read_en for 24 cycles -> ch7 byte5, ch7 byte6, aux1 back-to-back with no gap; addr_cur ends at 2.
- Reads of addr 0 and addr 60 -> 0x00.
- capture pulsed while busy -> shadow unchanged.
- rstn pulsed at the 4th bit -> outputs cleared immediately.
